// File: rtl/uart_tx_fsm.sv
// UART transmitter control FSM: sequences start, data, optional parity and stop bits,
// and drives the serializer enable, TX mux select, Busy and end-of-frame indicator.
module uart_tx_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic       Data_valid,
    input  logic       ser_done,
    input  logic       Par_en,
    output logic       ser_en,
    output logic [1:0] mux_sel,
    output logic       Busy,
    output logic       idle_data
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        START  = 4'd1,
        DATA   = 4'd2,
        PARITY = 4'd3,
        STOP   = 4'd4
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Unused codes fall through to the default arm and recover to IDLE.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = Data_valid ? START : IDLE;
            START:   state_d = DATA;
            DATA: begin
                if (!ser_done) begin
                    state_d = DATA;
                end else if (Par_en) begin
                    state_d = PARITY;
                end else begin
                    state_d = STOP;
                end
            end
            PARITY:  state_d = STOP;
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Busy      = 1'b0;
        ser_en    = 1'b0;
        mux_sel   = 2'd2;
        idle_data = 1'b0;
        case (state_q)
            START: begin
                Busy    = 1'b1;
                ser_en  = 1'b1;
                mux_sel = 2'd0;
            end
            DATA: begin
                Busy    = 1'b1;
                ser_en  = 1'b1;
                mux_sel = 2'd2;
            end
            PARITY: begin
                Busy    = 1'b1;
                mux_sel = 2'd3;
            end
            STOP: begin
                Busy      = 1'b1;
                mux_sel   = 2'd1;
                idle_data = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: directed vector table, hand-written reset corner cases,
// then randomized inputs checked against a frame-level reference model.
module tb_uart_tx_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Data_valid = 1'b0;
    logic       ser_done = 1'b0;
    logic       Par_en = 1'b0;
    logic       ser_en;
    logic [1:0] mux_sel;
    logic       Busy;
    logic       idle_data;

    int unsigned checks = 0;
    int unsigned errors = 0;

    uart_tx_fsm dut (
        .clk       (clk),
        .rst       (rst),
        .Data_valid(Data_valid),
        .ser_done  (ser_done),
        .Par_en    (Par_en),
        .ser_en    (ser_en),
        .mux_sel   (mux_sel),
        .Busy      (Busy),
        .idle_data (idle_data)
    );

    always #5 clk = ~clk;

    // Expected outputs packed as {Busy, ser_en, mux_sel[1:0], idle_data}.
    localparam logic [4:0] O_IDLE   = 5'b00100;
    localparam logic [4:0] O_START  = 5'b11000;
    localparam logic [4:0] O_DATA   = 5'b11100;
    localparam logic [4:0] O_PARITY = 5'b10110;
    localparam logic [4:0] O_STOP   = 5'b10011;

    typedef struct {
        logic       rst;
        logic       dv;
        logic       sd;
        logic       pe;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic d, logic s, logic p, logic [4:0] e);
        vec_t v;
        v.rst = r; v.dv = d; v.sd = s; v.pe = p; v.exp = e;
        return v;
    endfunction

    // Frame-level reference: which bit of the frame is on the line.
    // "I" idle, "S" start bit, "D" data bits, "P" parity bit, "T" stop bit.
    function automatic byte next_sym(byte cur, logic r, logic d, logic s, logic p);
        if (r) return "I";
        if (cur == "I") return d ? "S" : "I";
        if (cur == "S") return "D";
        if (cur == "D") return !s ? "D" : (p ? "P" : "T");
        if (cur == "P") return "T";
        return "I";
    endfunction

    function automatic logic [4:0] sym_out(byte s);
        case (s)
            "S":     return O_START;
            "D":     return O_DATA;
            "P":     return O_PARITY;
            "T":     return O_STOP;
            default: return O_IDLE;
        endcase
    endfunction

    task automatic step(input logic r, input logic d, input logic s, input logic p,
                        input logic [4:0] exp, input string name);
        logic [4:0] act;
        rst = r; Data_valid = d; ser_done = s; Par_en = p;
        @(posedge clk);
        #1;
        act = {Busy, ser_en, mux_sel, idle_data};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {Busy,ser_en,mux_sel,idle_data}=%b expected %b", name, act, exp);
        end
        @(negedge clk);
    endtask

    initial begin
        byte sym;
        logic r, d, s, p;

        // Reset with all other inputs active, then hold idle.
        vecs.push_back(mk(1, 1, 1, 1, O_IDLE));
        vecs.push_back(mk(0, 0, 0, 0, O_IDLE));
        vecs.push_back(mk(0, 0, 1, 1, O_IDLE));
        vecs.push_back(mk(0, 0, 0, 0, O_IDLE));
        // Parity frame.
        vecs.push_back(mk(0, 1, 0, 0, O_START));
        vecs.push_back(mk(0, 0, 0, 0, O_DATA));
        vecs.push_back(mk(0, 0, 1, 1, O_PARITY));
        vecs.push_back(mk(0, 1, 0, 0, O_STOP));
        // Back-to-back with Data_valid held: STOP -> IDLE -> START -> DATA -> STOP.
        vecs.push_back(mk(0, 1, 1, 0, O_IDLE));
        vecs.push_back(mk(0, 1, 1, 0, O_START));
        vecs.push_back(mk(0, 1, 1, 0, O_DATA));
        vecs.push_back(mk(0, 1, 1, 0, O_STOP));
        vecs.push_back(mk(0, 1, 1, 0, O_IDLE));
        // Long data phase: eight cycles in DATA, Par_en toggling is irrelevant.
        vecs.push_back(mk(0, 1, 0, 0, O_START));
        for (int unsigned i = 0; i < 8; i++)
            vecs.push_back(mk(0, i[0], 0, i[1], O_DATA));
        vecs.push_back(mk(0, 0, 1, 0, O_STOP));
        vecs.push_back(mk(0, 0, 0, 0, O_IDLE));
        // Reset while in PARITY, then a normal restart.
        vecs.push_back(mk(0, 1, 0, 0, O_START));
        vecs.push_back(mk(0, 0, 0, 0, O_DATA));
        vecs.push_back(mk(0, 0, 1, 1, O_PARITY));
        vecs.push_back(mk(1, 1, 0, 0, O_IDLE));
        vecs.push_back(mk(0, 1, 0, 0, O_START));
        vecs.push_back(mk(0, 0, 0, 0, O_DATA));
        vecs.push_back(mk(0, 0, 1, 0, O_STOP));
        vecs.push_back(mk(0, 0, 0, 0, O_IDLE));

        @(negedge clk);
        foreach (vecs[i])
            step(vecs[i].rst, vecs[i].dv, vecs[i].sd, vecs[i].pe, vecs[i].exp,
                 $sformatf("vec%0d", i));

        // Reset aborting START, DATA and STOP on the same edge.
        step(0, 1, 0, 0, O_START, "abort_start_a");
        step(1, 0, 0, 0, O_IDLE,  "abort_start_b");
        step(0, 1, 0, 0, O_START, "abort_data_a");
        step(0, 0, 0, 0, O_DATA,  "abort_data_b");
        step(1, 1, 1, 1, O_IDLE,  "abort_data_c");
        step(0, 0, 0, 0, O_IDLE,  "abort_data_d");
        step(0, 1, 0, 0, O_START, "abort_stop_a");
        step(0, 0, 1, 0, O_DATA,  "abort_stop_b");
        step(0, 0, 1, 0, O_STOP,  "abort_stop_c");
        step(1, 1, 0, 0, O_IDLE,  "abort_stop_d");

        // Randomized run against the frame-level model.
        sym = "I";
        for (int unsigned n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 40) == 0);
            d = $urandom_range(0, 1) == 1;
            s = ($urandom_range(0, 3) == 0);
            p = $urandom_range(0, 1) == 1;
            sym = next_sym(sym, r, d, s, p);
            step(r, d, s, p, sym_out(sym), $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
